// File: rtl/instruction_fetch.sv
// PC generator and IF/OF pipeline latch for the SimpleRISC pipeline.
// Drives a 1-cycle synchronous instruction memory and registers (pc, instr, valid).
module instruction_fetch #(
   parameter int unsigned   N        = 7,
   parameter logic [N-1:0]  RESET_PC = '0
) (
   input  logic          clka,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          branch_taken,
   input  logic [N-1:0]  branch_target,
   output logic [N-1:0]  imem_addr,
   input  logic [31:0]   imem_data,
   output logic [N-1:0]  if_pc,
   output logic [31:0]   if_instr,
   output logic          if_valid,
   output logic          done,
   output logic [31:0]   fetch_count
);

   typedef enum logic {StFetch, StDone} state_t;

   localparam logic [N-1:0] PcMax = '1;

   state_t       state;
   logic [N-1:0] pc;

   // Next-PC doubles as the memory address, so imem_data always reflects mem[pc].
   // The last address holds rather than wrapping when it is fetched.
   always_comb begin
      imem_addr = pc;
      if (!rst_n) begin
         imem_addr = RESET_PC;
      end else if (branch_taken) begin
         imem_addr = branch_target;
      end else if (stall || state == StDone || pc == PcMax) begin
         imem_addr = pc;
      end else begin
         imem_addr = pc + 1'b1;
      end
   end

   always_ff @(posedge clka) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         state       <= StFetch;
         if_pc       <= '0;
         if_instr    <= '0;
         if_valid    <= 1'b0;
         fetch_count <= '0;
      end else begin
         pc <= imem_addr;
         if (branch_taken) begin
            if_valid <= 1'b0;
            state    <= StFetch;
         end else if (!stall) begin
            if (state == StFetch) begin
               if_pc       <= pc;
               if_instr    <= imem_data;
               if_valid    <= 1'b1;
               fetch_count <= fetch_count + 32'd1;
               if (pc == PcMax) begin
                  state <= StDone;
               end
            end else begin
               if_valid <= 1'b0;
            end
         end
      end
   end

   assign done = (state == StDone);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic checked
// against a behavioural model of the fetch sequence.
module tb_instruction_fetch;

   logic        clka = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [6:0]  branch_target = '0;
   logic [6:0]  imem_addr;
   logic [31:0] imem_data;
   logic [6:0]  if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        done;
   logic [31:0] fetch_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: address currently being read, stop flag, expected latch.
   logic [6:0]  m_pc;
   bit          m_done;
   logic [6:0]  e_pc;
   logic [31:0] e_instr;
   bit          e_valid;
   logic [31:0] e_count;

   always #5 clka = ~clka;

   instruction_fetch #(.N(7), .RESET_PC(7'd0)) dut (
      .clka          (clka),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .if_pc         (if_pc),
      .if_instr      (if_instr),
      .if_valid      (if_valid),
      .done          (done),
      .fetch_count   (fetch_count)
   );

   // Instruction memory: 1-cycle registered read, mem[i] = A5A5_0000 | i.
   always @(posedge clka) imem_data <= 32'hA5A5_0000 | {25'd0, imem_addr};

   function automatic logic [31:0] word(input logic [6:0] a);
      return 32'hA5A5_0000 | {25'd0, a};
   endfunction

   // Address the fetcher should request given current inputs and model state.
   function automatic logic [6:0] model_addr();
      if (!rst_n) return 7'd0;
      if (branch_taken) return branch_target;
      if (stall || m_done) return m_pc;
      if (m_pc == 7'd127) return m_pc;  // last word fetched: stop, no wrap
      return m_pc + 7'd1;
   endfunction

   task automatic drive(input bit r, input bit s, input bit b, input logic [6:0] t);
      rst_n = r; stall = s; branch_taken = b; branch_target = t;
   endtask

   task automatic tick();
      logic [6:0] na;
      @(posedge clka);
      na = model_addr();
      if (!rst_n) begin
         m_done = 0; e_pc = 0; e_instr = 0; e_valid = 0; e_count = 0;
      end else if (branch_taken) begin
         e_valid = 0; m_done = 0;
      end else if (!stall) begin
         if (!m_done) begin
            e_pc = m_pc; e_instr = word(m_pc); e_valid = 1; e_count = e_count + 1;
            if (m_pc == 7'd127) m_done = 1;
         end else begin
            e_valid = 0;
         end
      end
      m_pc = na;
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      tick();
      tick();
      drive(1, 0, 0, 0);
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0);
      repeat (3) tick();
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
      n_checks++; if (if_pc !== 7'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", if_pc); end
      n_checks++; if (if_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", if_instr); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
      n_checks++; if (imem_addr !== 7'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", imem_addr); end
      drive(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (if_valid !== 1'b1 || if_pc !== 7'(i) || if_instr !== (32'hA5A5_0000 | i))
         begin n_fail++; $display("FAIL seq_%0d: got v=%b pc=%0d instr=%h expected v=1 pc=%0d", i, if_valid, if_pc, if_instr, i); end
      end
      n_checks++; if (fetch_count !== 32'd4) begin n_fail++; $display("FAIL seq_count: got %0d expected 4", fetch_count); end
   endtask

   task automatic test_stall();
      do_reset();
      repeat (3) tick();
      drive(1, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++; if (imem_addr !== 7'd3) begin n_fail++; $display("FAIL stall_addr: got %0d expected 3", imem_addr); end
         tick();
         n_checks++; if (if_pc !== 7'd2 || if_instr !== 32'hA5A5_0002 || if_valid !== 1'b1)
         begin n_fail++; $display("FAIL stall_hold: got pc=%0d instr=%h v=%b expected pc=2", if_pc, if_instr, if_valid); end
      end
      drive(1, 0, 0, 0);
      for (int i = 3; i < 5; i++) begin
         tick();
         n_checks++; if (if_pc !== 7'(i) || if_instr !== (32'hA5A5_0000 | i) || if_valid !== 1'b1)
         begin n_fail++; $display("FAIL stall_resume: got pc=%0d instr=%h expected pc=%0d", if_pc, if_instr, i); end
      end
      n_checks++; if (fetch_count !== 32'd5) begin n_fail++; $display("FAIL stall_count: got %0d expected 5", fetch_count); end
   endtask

   task automatic test_branch();
      do_reset();
      repeat (6) tick();
      n_checks++; if (if_pc !== 7'd5) begin n_fail++; $display("FAIL br_setup: got %0d expected 5", if_pc); end
      drive(1, 0, 1, 7'd40);
      tick();
      n_checks++; if (if_valid !== 1'b0 || fetch_count !== 32'd6)
      begin n_fail++; $display("FAIL br_flush: got v=%b count=%0d expected v=0 count=6", if_valid, fetch_count); end
      drive(1, 0, 0, 0);
      tick();
      n_checks++; if (if_pc !== 7'd40 || if_instr !== 32'hA5A5_0028 || if_valid !== 1'b1 || fetch_count !== 32'd7)
      begin n_fail++; $display("FAIL br_target: got pc=%0d instr=%h count=%0d expected pc=40 count=7", if_pc, if_instr, fetch_count); end
   endtask

   task automatic test_branch_stall();
      drive(1, 1, 1, 7'd10);
      #1;
      n_checks++; if (imem_addr !== 7'd10) begin n_fail++; $display("FAIL brst_addr: got %0d expected 10", imem_addr); end
      tick();
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL brst_flush: got v=%b expected 0", if_valid); end
      drive(1, 0, 0, 0);
      tick();
      n_checks++; if (if_pc !== 7'd10 || if_valid !== 1'b1 || if_instr !== 32'hA5A5_000A)
      begin n_fail++; $display("FAIL brst_target: got pc=%0d v=%b expected pc=10 v=1", if_pc, if_valid); end
   endtask

   task automatic test_end_of_memory();
      drive(1, 0, 1, 7'd125);
      tick();
      drive(1, 0, 0, 0);
      for (int i = 125; i < 128; i++) begin
         tick();
         n_checks++; if (if_pc !== 7'(i) || if_valid !== 1'b1)
         begin n_fail++; $display("FAIL end_seq: got pc=%0d v=%b expected pc=%0d", if_pc, if_valid, i); end
      end
      repeat (2) tick();
      n_checks++; if (done !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 7'd127)
      begin n_fail++; $display("FAIL end_done: got done=%b v=%b addr=%0d expected 1 0 127", done, if_valid, imem_addr); end
      drive(1, 0, 1, 7'd0);
      tick();
      n_checks++; if (done !== 1'b0 || if_valid !== 1'b0)
      begin n_fail++; $display("FAIL end_redirect: got done=%b v=%b expected 0 0", done, if_valid); end
      drive(1, 0, 0, 0);
      tick();
      n_checks++; if (if_pc !== 7'd0 || if_valid !== 1'b1 || if_instr !== 32'hA5A5_0000)
      begin n_fail++; $display("FAIL end_refetch: got pc=%0d v=%b expected pc=0 v=1", if_pc, if_valid); end
   endtask

   task automatic test_mid_reset();
      repeat (3) tick();
      drive(0, 1, 0, 0);
      #1;
      n_checks++; if (imem_addr !== 7'd0) begin n_fail++; $display("FAIL mrst_addr: got %0d expected 0", imem_addr); end
      tick();
      n_checks++; if (if_pc !== 7'd0 || if_instr !== 32'd0 || if_valid !== 1'b0 || done !== 1'b0 || fetch_count !== 32'd0)
      begin n_fail++; $display("FAIL mrst_state: got pc=%0d instr=%h v=%b done=%b count=%0d expected zeros", if_pc, if_instr, if_valid, done, fetch_count); end
      drive(1, 0, 0, 0);
      tick();
      n_checks++; if (if_pc !== 7'd0 || if_valid !== 1'b1 || if_instr !== 32'hA5A5_0000 || fetch_count !== 32'd1)
      begin n_fail++; $display("FAIL mrst_refetch: got pc=%0d v=%b count=%0d expected pc=0 v=1 count=1", if_pc, if_valid, fetch_count); end
   endtask

   task automatic test_random();
      logic [6:0] t;
      for (int i = 0; i < 600; i++) begin
         t = ($urandom_range(0, 9) < 3) ? 7'($urandom_range(118, 127)) : 7'($urandom_range(0, 127));
         drive(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 25),
               ($urandom_range(0, 99) < 6), t);
         #1;
         n_checks++; if (imem_addr !== model_addr())
         begin n_fail++; $display("FAIL rnd_addr[%0d]: got %0d expected %0d", i, imem_addr, model_addr()); end
         tick();
         n_checks++; if (if_valid !== e_valid || done !== m_done || fetch_count !== e_count)
         begin n_fail++; $display("FAIL rnd_ctrl[%0d]: got v=%b done=%b count=%0d expected v=%b done=%b count=%0d",
                                  i, if_valid, done, fetch_count, e_valid, m_done, e_count); end
         if (e_valid) begin
            n_checks++; if (if_pc !== e_pc || if_instr !== e_instr)
            begin n_fail++; $display("FAIL rnd_data[%0d]: got pc=%0d instr=%h expected pc=%0d instr=%h",
                                     i, if_pc, if_instr, e_pc, e_instr); end
         end
      end
   endtask

   initial begin
      m_pc = 0; m_done = 0; e_pc = 0; e_instr = 0; e_valid = 0; e_count = 0;
      #1;
      test_reset();
      test_stall();
      test_branch();
      test_branch_stall();
      test_end_of_memory();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
